// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the cache miss / write-through port.
//
// A one-cycle mem_req is captured in IDLE. A read fetches a full BLOCKSZ-bit line
// from the WIDTH-bit backing bus in BEATS beats. A write performs a single WIDTH-bit
// bus write. Both finish with a one-cycle mem_data_valid strobe.
//
// Optional build macro: MEMRSP_CRITICAL_WORD_FIRST_EN
//   defined   : read beats start at the requested word and wrap modulo BEATS
//   undefined : read beats always run in lane order 0..BEATS-1
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_req         one-cycle request pulse from the cache
//   mem_address     request byte address
//   mem_wr_en       1 = write request, 0 = line read
//   mem_data_out    write data from the cache
//   mem_data_in     assembled line returned to the cache
//   mem_data_valid  one-cycle completion strobe
//   busy            high from capture through the mem_data_valid cycle
//   bus_req/bus_wr/bus_addr/bus_wdata  backing-bus request (held until bus_ack)
//   bus_ack/bus_rdata                  backing-bus beat accept and read data
module mem_responder #(
    parameter int BLOCKSZ     = 512,
    parameter int WIDTH       = 64,
    parameter int ADDRESSSIZE = 64,
    parameter int OFFWIDTH    = 6,
    parameter int BEATS       = BLOCKSZ / WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic [ADDRESSSIZE-1:0] mem_address,
    input  logic                   mem_wr_en,
    input  logic [WIDTH-1:0]       mem_data_out,
    output logic [BLOCKSZ-1:0]     mem_data_in,
    output logic                   mem_data_valid,
    output logic                   busy,
    output logic                   bus_req,
    output logic                   bus_wr,
    output logic [ADDRESSSIZE-1:0] bus_addr,
    output logic [WIDTH-1:0]       bus_wdata,
    input  logic                   bus_ack,
    input  logic [WIDTH-1:0]       bus_rdata
);

    localparam int BEAT_W     = $clog2(BEATS);
    localparam int BYTE_W     = $clog2(WIDTH / 8);
    localparam int LANE_SH    = $clog2(WIDTH);
    localparam int LINE_IDX_W = $clog2(BLOCKSZ);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_WORD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [BEAT_W-1:0]        beat_r;
    logic [BEAT_W-1:0]        beat_next_s;
    logic [ADDRESSSIZE-1:0]   addr_r;
    logic [ADDRESSSIZE-1:0]   addr_next_s;
    logic [WIDTH-1:0]         wdata_r;
    logic [WIDTH-1:0]         wdata_next_s;
    logic [BLOCKSZ-1:0]       line_r;
    logic                     valid_r;
    logic                     busy_r;
    logic                     bus_req_r;
    logic                     bus_wr_r;
    logic [ADDRESSSIZE-1:0]   bus_addr_r;
    logic [WIDTH-1:0]         bus_wdata_r;
    logic [BEAT_W-1:0]        lane_next_s;
    logic [ADDRESSSIZE-1:0]   bus_addr_next_s;
    logic [BEAT_W-1:0]        lane_cur_s;
    logic [LINE_IDX_W-1:0]    lane_base_s;
    logic                     rd_ack_s;
    logic                     unused_addr_s;

    // Byte-within-word address bits never reach the word-aligned bus.
    assign unused_addr_s = ^addr_r[BYTE_W-1:0];

    assign mem_data_in    = line_r;
    assign mem_data_valid = valid_r;
    assign busy           = busy_r;
    assign bus_req        = bus_req_r;
    assign bus_wr         = bus_wr_r;
    assign bus_addr       = bus_addr_r;
    assign bus_wdata      = bus_wdata_r;

    // Next-state, beat counter and request capture.
    always_comb begin
        state_next_s = state_r;
        beat_next_s  = beat_r;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (mem_req) begin
                    addr_next_s  = mem_address;
                    wdata_next_s = mem_data_out;
                    beat_next_s  = '0;
                    if (mem_wr_en) begin
                        state_next_s = WR_WORD;
                    end else begin
                        state_next_s = RD_BEAT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_BEAT: begin
                if (bus_ack) begin
                    beat_next_s = beat_r + BEAT_W'(1);
                    if (beat_r == LAST_BEAT) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = RD_BEAT;
                    end
                end else begin
                    state_next_s = RD_BEAT;
                end
            end
            WR_WORD: begin
                if (bus_ack) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WR_WORD;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Lane fetched by the upcoming beat; critical-word-first rotates by the requested word.
    always_comb begin
`ifdef MEMRSP_CRITICAL_WORD_FIRST_EN
        lane_next_s = beat_next_s + addr_next_s[OFFWIDTH-1:BYTE_W];
`else
        lane_next_s = beat_next_s;
`endif
    end

    // Bus address for the next cycle, so the registered output lines up with the state.
    always_comb begin
        bus_addr_next_s = '0;
        if (state_next_s == RD_BEAT) begin
            bus_addr_next_s = {addr_next_s[ADDRESSSIZE-1:OFFWIDTH], lane_next_s, {BYTE_W{1'b0}}};
        end else if (state_next_s == WR_WORD) begin
            bus_addr_next_s = {addr_next_s[ADDRESSSIZE-1:BYTE_W], {BYTE_W{1'b0}}};
        end else begin
            bus_addr_next_s = '0;
        end
    end

    // The lane being filled is the one currently on the bus.
    always_comb begin
        rd_ack_s    = (state_r == RD_BEAT) && bus_ack;
        lane_cur_s  = bus_addr_r[OFFWIDTH-1:BYTE_W];
        lane_base_s = {lane_cur_s, {LANE_SH{1'b0}}};
    end

    // State, capture registers, registered outputs and line buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            beat_r      <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            line_r      <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_wr_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
        end else begin
            state_r     <= state_next_s;
            beat_r      <= beat_next_s;
            addr_r      <= addr_next_s;
            wdata_r     <= wdata_next_s;
            valid_r     <= (state_next_s == RESP);
            busy_r      <= (state_next_s != IDLE);
            bus_req_r   <= (state_next_s == RD_BEAT) || (state_next_s == WR_WORD);
            bus_wr_r    <= (state_next_s == WR_WORD);
            bus_addr_r  <= bus_addr_next_s;
            bus_wdata_r <= (state_next_s == WR_WORD) ? wdata_next_s : '0;
            if (rd_ack_s) begin
                line_r[lane_base_s +: WIDTH] <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a table of request vectors with
// hand-computed timing/addresses, a wait-state bus memory, and hand-written
// sequences for idle acks and mid-transaction reset.
module tb_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req = 1'b0;
    logic [63:0]  mem_address = 64'd0;
    logic         mem_wr_en = 1'b0;
    logic [63:0]  mem_data_out = 64'd0;
    logic [511:0] mem_data_in;
    logic         mem_data_valid;
    logic         busy;
    logic         bus_req;
    logic         bus_wr;
    logic [63:0]  bus_addr;
    logic [63:0]  bus_wdata;
    logic         bus_ack = 1'b0;
    logic [63:0]  bus_rdata = 64'd0;

    mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_address    (mem_address),
        .mem_wr_en      (mem_wr_en),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .busy           (busy),
        .bus_req        (bus_req),
        .bus_wr         (bus_wr),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          nwait = 0;
    logic [63:0] rbase = 64'd0;
    logic        force_ack = 1'b0;
    logic [63:0] exp_lane [8];

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          nw;
        logic [63:0] base;
        int          exp_valid;
        int          exp_beats;
        logic [2:0]  exp_start;
        int          spur_a;
        int          spur_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus memory: acks after nwait wait cycles, data = rbase + lane of the address.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (wcnt == nwait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rbase + {61'd0, bus_addr[5:3]};
                    wcnt      = 0;
                end else begin
                    bus_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus_ack = force_ack;
                wcnt    = 0;
            end
        end
    end

    task automatic check_line(input string name);
        for (int i = 0; i < 8; i++) begin
            check(name, mem_data_in[i*64 +: 64], exp_lane[i]);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, {63'd0, mem_data_valid}, 64'd0);
        check({name, "_busy"},  {63'd0, busy}, 64'd0);
        check({name, "_req"},   {63'd0, bus_req}, 64'd0);
        check({name, "_wr"},    {63'd0, bus_wr}, 64'd0);
        check({name, "_addr"},  bus_addr, 64'd0);
        check({name, "_wdata"}, bus_wdata, 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int          beats;
        int          nvalid;
        int          vcyc;
        logic        pend;
        logic [63:0] paddr;
        logic [63:0] eaddr;
        beats  = 0;
        nvalid = 0;
        vcyc   = -1;
        pend   = 1'b0;
        paddr  = 64'd0;
        nwait  = v.nw;
        rbase  = v.base;
        @(negedge clk);
        mem_req      = 1'b1;
        mem_address  = v.addr;
        mem_wr_en    = v.wr;
        mem_data_out = v.wdata;
        for (int cyc = 1; cyc <= v.exp_valid + 3 && cyc < 80; cyc++) begin
            @(negedge clk);
            #1;
            mem_req = (cyc == v.spur_a) || (cyc == v.spur_b);
            check("busy", {63'd0, busy}, (cyc <= v.exp_valid) ? 64'd1 : 64'd0);
            if (bus_req) begin
                check("bus_wr", {63'd0, bus_wr}, {63'd0, v.wr});
                if (pend) begin
                    check("addr_hold", bus_addr, paddr);
                end
                if (bus_ack) begin
                    if (v.wr) begin
                        eaddr = {v.addr[63:3], 3'b000};
                        check("bus_wdata", bus_wdata, v.wdata);
                    end else begin
                        eaddr = {v.addr[63:6], 3'(v.exp_start + beats), 3'b000};
                    end
                    check("bus_addr", bus_addr, eaddr);
                    beats++;
                    pend = 1'b0;
                end else begin
                    pend  = 1'b1;
                    paddr = bus_addr;
                end
            end
            if (mem_data_valid) begin
                nvalid++;
                vcyc = cyc;
            end
        end
        mem_req = 1'b0;
        check("valid_cycle", 64'(vcyc), 64'(v.exp_valid));
        check("valid_count", 64'(nvalid), 64'd1);
        check("beat_count", 64'(beats), 64'(v.exp_beats));
        check("req_after", {63'd0, bus_req}, 64'd0);
        if (!v.wr) begin
            for (int i = 0; i < 8; i++) begin
                exp_lane[i] = v.base + 64'(i);
            end
        end
        check_line("line");
    endtask

    initial begin
        int nvalid;
        int beats;
`ifdef MEMRSP_CRITICAL_WORD_FIRST_EN
        vecs[0] = '{1'b0, 64'h1000_0040, 64'd0, 0, 64'hA000, 9, 8, 3'd0, 0, 0};
        vecs[3] = '{1'b0, 64'h1000_0068, 64'd0, 0, 64'hA000, 9, 8, 3'd5, 4, 9};
        vecs[5] = '{1'b0, 64'h4000_0078, 64'd0, 1, 64'hD000, 17, 8, 3'd7, 0, 0};
`else
        vecs[0] = '{1'b0, 64'h1000_0040, 64'd0, 0, 64'hA000, 9, 8, 3'd0, 0, 0};
        vecs[3] = '{1'b0, 64'h1000_0068, 64'd0, 0, 64'hA000, 9, 8, 3'd0, 4, 9};
        vecs[5] = '{1'b0, 64'h4000_0078, 64'd0, 1, 64'hD000, 17, 8, 3'd0, 0, 0};
`endif
        vecs[1] = '{1'b1, 64'h2000_001C, 64'hDEAD_BEEF, 0, 64'd0, 2, 1, 3'd0, 0, 0};
        vecs[2] = '{1'b0, 64'h1000_0040, 64'd0, 2, 64'hB000, 25, 8, 3'd0, 0, 0};
        vecs[4] = '{1'b1, 64'h3000_0007, 64'h0123_4567_89AB_CDEF, 1, 64'd0, 3, 1, 3'd2, 2, 0};
        for (int i = 0; i < 8; i++) begin
            exp_lane[i] = 64'd0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check_line("reset_line");

        for (int k = 0; k < 6; k++) begin
            run_txn(vecs[k]);
        end

        // bus_ack while idle must be ignored.
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_idle_outputs("idle_ack");
        end
        force_ack = 1'b0;
        check_line("idle_ack_line");

        // Reset after beat 3 has been accepted.
        nwait = 0;
        rbase = 64'hC000;
        beats = 0;
        @(negedge clk);
        mem_req     = 1'b1;
        mem_address = 64'h5000_0000;
        mem_wr_en   = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            #1;
            mem_req = 1'b0;
            if (bus_req && bus_ack) begin
                beats++;
            end
            if (cyc == 5) begin
                rst = 1'b1;
            end
        end
        check("rst_beats_before", 64'(beats), 64'd5);
        @(negedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        for (int i = 0; i < 8; i++) begin
            exp_lane[i] = 64'd0;
        end
        check_line("rst_line");
        nvalid = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (mem_data_valid) begin
                nvalid++;
            end
        end
        check("rst_no_valid", 64'(nvalid), 64'd0);
        run_txn(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
